// File: rtl/dlfloat_mac_seq.sv
// dlfloat_mac_seq: byte-serial DLFloat16 multiply-accumulate sequencer with NUM_ACC
// independent accumulators. Format: s[15], e[14:9] (bias 31), f[8:0], hidden 1.
// Frame: command byte {op[1:0], idx[5:0]} then payload bytes, high byte first.
//   op 00 MAC (A,B), 01 CLEAR, 10 READ, 11 LOAD (value).
// Optional feature: define DLFMAC_STICKY_FLAGS_EN for per-accumulator sticky flags
// {flushed, saturated}; READ then emits a third byte {6'b0, flags}.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ena                             enable; low holds all state and outputs
//   in_valid, in_data, in_ready     command/payload byte stream
//   out_valid, out_data, out_ready  result byte stream
//   err                             one-cycle pulse after a frame with idx >= NUM_ACC
module dlfloat_mac_seq #(
  parameter int unsigned NUM_ACC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       err
);

  localparam int unsigned IDX_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam logic [6:0]  NumAccW = 7'(NUM_ACC);
`ifdef DLFMAC_STICKY_FLAGS_EN
  localparam logic [1:0]  LastByte = 2'd2;
`else
  localparam logic [1:0]  LastByte = 2'd1;
`endif
  localparam logic [1:0]  OpMac   = 2'b00;
  localparam logic [1:0]  OpClear = 2'b01;
  localparam logic [1:0]  OpRead  = 2'b10;
  localparam logic [1:0]  OpLoad  = 2'b11;

  typedef enum logic [1:0] {StIdle, StArg, StExec, StSend} state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [IDX_W-1:0]   idx_q;
  logic               bad_q;
  logic [1:0]         cnt_q;
  logic [31:0]        pay_q;
  logic [1:0]         obyte_q;
  logic               out_valid_q;
  logic [7:0]         out_data_q;
  logic               err_q;
  logic [15:0]        acc_q [NUM_ACC];
`ifdef DLFMAC_STICKY_FLAGS_EN
  logic [1:0]         flg_q [NUM_ACC];
`endif

  logic             in_bad;
  logic [IDX_W-1:0] in_idx;

  assign in_bad    = {1'b0, in_data[5:0]} >= NumAccW;
  assign in_idx    = in_data[IDX_W-1:0];
  assign in_ready  = ena && ((state_q == StIdle) || (state_q == StArg));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

  // Input operand rules: e=0 is zero (fraction and sign dropped), e=63 clamps to max finite.
  function automatic logic [15:0] norm_in(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[14:9] == 6'd0) begin
      r = 16'h0000;
    end else if (v[14:9] == 6'h3F) begin
      r = {v[15], 6'd62, 9'h1FF};
    end
    return r;
  endfunction

  // MAC datapath: acc[idx_q] + A*B, all steps truncating toward zero.
  logic [15:0]       a_n, b_n, acc_cur, load_n, mac_res;
  logic              mac_sat, mac_flush;
  logic [10:0]       prod_hi;
  logic signed [8:0] pe, re;
  logic              ps, big_s, sml_s, rs;
  logic [5:0]        pexp, aexp, big_e, sml_e, diff;
  logic [9:0]        pm, am, big_m, sml_m, sml_sh;
  logic [8:0]        rm;
  logic [10:0]       sum;
  logic [3:0]        lz;

  always_comb begin
    a_n       = norm_in(pay_q[31:16]);
    b_n       = norm_in(pay_q[15:0]);
    load_n    = norm_in(pay_q[15:0]);
    acc_cur   = acc_q[idx_q];
    mac_sat   = 1'b0;
    mac_flush = 1'b0;

    // Keep the top 11 bits of the 20-bit significand product; bit 10 means product >= 2.0.
    prod_hi = 11'((20'({1'b1, a_n[8:0]}) * 20'({1'b1, b_n[8:0]})) >> 9);
    ps      = a_n[15] ^ b_n[15];
    pe      = $signed({3'b000, a_n[14:9]}) + $signed({3'b000, b_n[14:9]}) - 9'sd31
              + (prod_hi[10] ? 9'sd1 : 9'sd0);
    if ((a_n[14:9] == 6'd0) || (b_n[14:9] == 6'd0)) begin
      pexp = 6'd0;
      pm   = 10'd0;
    end else if (pe > 9'sd62) begin
      pexp    = 6'd62;
      pm      = 10'h3FF;
      mac_sat = 1'b1;
    end else if (pe < 9'sd1) begin
      pexp      = 6'd0;
      pm        = 10'd0;
      mac_flush = 1'b1;
    end else begin
      pexp = pe[5:0];
      pm   = {1'b1, prod_hi[10] ? prod_hi[9:1] : prod_hi[8:0]};
    end

    aexp = acc_cur[14:9];
    am   = (aexp == 6'd0) ? 10'd0 : {1'b1, acc_cur[8:0]};

    if (pexp >= aexp) begin
      big_s = ps;         big_e = pexp; big_m = pm;
      sml_s = acc_cur[15]; sml_e = aexp; sml_m = am;
    end else begin
      big_s = acc_cur[15]; big_e = aexp; big_m = am;
      sml_s = ps;          sml_e = pexp; sml_m = pm;
    end
    diff   = big_e - sml_e;
    sml_sh = sml_m >> diff;

    if (big_s == sml_s) begin
      sum = {1'b0, big_m} + {1'b0, sml_sh};
      rs  = big_s;
    end else if (big_m >= sml_sh) begin
      sum = {1'b0, big_m - sml_sh};
      rs  = big_s;
    end else begin
      sum = {1'b0, sml_sh - big_m};
      rs  = sml_s;
    end

    lz = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (sum[i]) lz = 4'(9 - i);
    end
    if (sum[10]) begin
      rm = sum[9:1];
      re = $signed({3'b000, big_e}) + 9'sd1;
    end else begin
      rm = 9'(sum[9:0] << lz);
      re = $signed({3'b000, big_e}) - $signed({5'b00000, lz});
    end

    if (sum == 11'd0) begin
      mac_res = 16'h0000;
    end else if (re > 9'sd62) begin
      mac_res = {rs, 6'd62, 9'h1FF};
      mac_sat = 1'b1;
    end else if (re < 9'sd1) begin
      mac_res   = 16'h0000;
      mac_flush = 1'b1;
    end else begin
      mac_res = {rs, re[5:0], rm};
    end
  end

`ifndef DLFMAC_STICKY_FLAGS_EN
  logic unused_flags;
  assign unused_flags = mac_sat ^ mac_flush;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 2'b00;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      cnt_q       <= 2'd0;
      pay_q       <= 32'h0;
      obyte_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      err_q       <= 1'b0;
      acc_q       <= '{default: '0};
`ifdef DLFMAC_STICKY_FLAGS_EN
      flg_q       <= '{default: '0};
`endif
    end else if (ena) begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q  <= in_data[7:6];
            idx_q <= in_idx;
            bad_q <= in_bad;
            cnt_q <= 2'd0;
            unique case (in_data[7:6])
              OpMac, OpLoad: state_q <= StArg;
              OpClear: begin
                state_q <= StExec;
                err_q   <= in_bad;
              end
              OpRead: begin
                if (in_bad) begin
                  state_q <= StExec;
                  err_q   <= 1'b1;
                end else begin
                  state_q     <= StSend;
                  out_valid_q <= 1'b1;
                  out_data_q  <= acc_q[in_idx][15:8];
                  obyte_q     <= 2'd0;
                end
              end
            endcase
          end
        end
        StArg: begin
          if (in_valid) begin
            pay_q <= {pay_q[23:0], in_data};
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == ((op_q == OpMac) ? 2'd3 : 2'd1)) begin
              state_q <= StExec;
              err_q   <= bad_q;
            end
          end
        end
        StExec: begin
          state_q <= StIdle;
          if (!bad_q) begin
            unique case (op_q)
              OpMac: begin
                acc_q[idx_q] <= mac_res;
`ifdef DLFMAC_STICKY_FLAGS_EN
                flg_q[idx_q] <= flg_q[idx_q] | {mac_flush, mac_sat};
`endif
              end
              OpClear: begin
                acc_q[idx_q] <= 16'h0000;
`ifdef DLFMAC_STICKY_FLAGS_EN
                flg_q[idx_q] <= 2'b00;
`endif
              end
              OpLoad: begin
                acc_q[idx_q] <= load_n;
`ifdef DLFMAC_STICKY_FLAGS_EN
                flg_q[idx_q] <= 2'b00;
`endif
              end
              default: ;
            endcase
          end
        end
        StSend: begin
          if (out_ready) begin
            if (obyte_q == LastByte) begin
              out_valid_q <= 1'b0;
              state_q     <= StIdle;
            end else begin
              obyte_q <= obyte_q + 2'd1;
`ifdef DLFMAC_STICKY_FLAGS_EN
              out_data_q <= (obyte_q == 2'd0) ? acc_q[idx_q][7:0] : {6'b0, flg_q[idx_q]};
`else
              out_data_q <= acc_q[idx_q][7:0];
`endif
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Self-checking bench for dlfloat_mac_seq: directed cases plus randomized command
// streams with handshake gaps and enable drops, checked against a value-level model.
`timescale 1ns/1ps
module tb_dlfloat_mac_seq;
  localparam int NACC = 4;
`ifdef DLFMAC_STICKY_FLAGS_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic       err;

  int n_vec = 0;
  int n_err = 0;
  int mode = 0;  // 0: ideal, 1: random gaps and ena drops, 2: out_ready held low

  logic [15:0] acc_m [NACC];
  logic [1:0]  flg_m [NACC];
  logic [7:0]  obytes [$];
  int          err_pulses = 0;
  int          hold_viol = 0;
  logic        err_d = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  hold_data = 8'h00;

  always #5 clk = ~clk;

  dlfloat_mac_seq #(.NUM_ACC(NACC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Output collector, hold-stability and err pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold  <= 1'b0;
      err_d <= 1'b0;
    end else begin
      if (out_valid && out_ready && ena) obytes.push_back(out_data);
      if (hold && !(out_valid && out_data == hold_data)) hold_viol <= hold_viol + 1;
      hold      <= out_valid && !(out_ready && ena);
      hold_data <= out_data;
      if (err && !err_d) err_pulses <= err_pulses + 1;
      err_d <= err;
    end
  end

  always @(posedge clk) begin
    #1;
    case (mode)
      1: begin
        ena       = ($urandom_range(0, 5) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end
      2: begin
        ena       = 1'b1;
        out_ready = 1'b0;
      end
      default: begin
        ena       = 1'b1;
        out_ready = 1'b1;
      end
    endcase
  end

  // ---------------- reference model (value level) ----------------
  function automatic void unpk(input logic [15:0] v, output int s, output int e, output int m);
    s = v[15];
    e = v[14:9];
    m = 512 + v[8:0];
    if (e == 0) begin
      s = 0;
      m = 0;
    end else if (e == 63) begin
      e = 62;
      m = 1023;
    end
  endfunction

  function automatic logic [15:0] pk(input int s, input int e0, input int m0,
                                     output logic sat, output logic fl);
    int e;
    int m;
    e   = e0;
    m   = m0;
    sat = 1'b0;
    fl  = 1'b0;
    if (m == 0) return 16'h0000;
    while (m >= 1024) begin m = m / 2; e++; end
    while (m < 512) begin m = m * 2; e--; end
    if (e > 62) begin
      sat = 1'b1;
      return {s[0], 6'd62, 9'h1FF};
    end
    if (e < 1) begin
      fl = 1'b1;
      return 16'h0000;
    end
    return {s[0], e[5:0], m[8:0]};
  endfunction

  function automatic void model_mac(input int idx, input logic [15:0] a, input logic [15:0] b);
    int sa, ea, ma, sb, eb, mb, sp, ep, mp, sc, ec, mc, e, sum;
    logic s1, f1, s2, f2;
    logic [15:0] p;
    s1 = 1'b0; f1 = 1'b0; s2 = 1'b0; f2 = 1'b0;
    unpk(a, sa, ea, ma);
    unpk(b, sb, eb, mb);
    if (ma == 0 || mb == 0) p = 16'h0000;
    else p = pk(sa ^ sb, ea + eb - 31, (ma * mb) >> 9, s1, f1);
    unpk(p, sp, ep, mp);
    unpk(acc_m[idx], sc, ec, mc);
    if (ep >= ec) begin
      e  = ep;
      mc = mc >> (ep - ec);
    end else begin
      e  = ec;
      mp = mp >> (ec - ep);
    end
    sum = (sp != 0 ? -mp : mp) + (sc != 0 ? -mc : mc);
    if (sum == 0) acc_m[idx] = 16'h0000;
    else acc_m[idx] = pk((sum < 0) ? 1 : 0, e, (sum < 0) ? -sum : sum, s2, f2);
    flg_m[idx] = flg_m[idx] | {f1 | f2, s1 | s2};
  endfunction

  function automatic logic [15:0] norm16(input logic [15:0] v);
    int s, e, m;
    unpk(v, s, e, m);
    if (m == 0) return 16'h0000;
    return {s[0], e[5:0], m[8:0]};
  endfunction

  function automatic logic [15:0] rnd_val();
    logic [5:0] e;
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       e = 6'd0;
      1:       e = 6'd63;
      2:       e = 6'($urandom_range(1, 8));
      3:       e = 6'($urandom_range(55, 62));
      default: e = 6'($urandom_range(24, 38));
    endcase
    return {1'($urandom), e, 9'($urandom)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NACC; i++) begin
      acc_m[i] = 16'h0000;
      flg_m[i] = 2'b00;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic push(input logic [7:0] b);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      if (mode == 1 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      @(negedge clk);
      done = in_valid && in_ready && ena;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 300) begin
        check("push_accept", {31'b0, done}, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic mac(input int idx, input logic [15:0] a, input logic [15:0] b);
    push({2'b00, 6'(idx)});
    push(a[15:8]); push(a[7:0]); push(b[15:8]); push(b[7:0]);
    if (idx < NACC) model_mac(idx, a, b);
  endtask

  task automatic clr(input int idx);
    push({2'b01, 6'(idx)});
    if (idx < NACC) begin
      acc_m[idx] = 16'h0000;
      flg_m[idx] = 2'b00;
    end
  endtask

  task automatic ld(input int idx, input logic [15:0] v);
    push({2'b11, 6'(idx)});
    push(v[15:8]); push(v[7:0]);
    if (idx < NACC) begin
      acc_m[idx] = norm16(v);
      flg_m[idx] = 2'b00;
    end
  endtask

  task automatic rd(input int idx, input string tag, output logic [15:0] got);
    int cyc;
    cyc = 0;
    got = 16'hDEAD;
    obytes.delete();
    push({2'b10, 6'(idx)});
    while (obytes.size() < NB && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check({tag, "_nbytes"}, obytes.size(), NB);
    if (obytes.size() >= 2) begin
      got = {obytes[0], obytes[1]};
      check({tag, "_val"}, got, acc_m[idx]);
    end
`ifdef DLFMAC_STICKY_FLAGS_EN
    if (obytes.size() >= 3) check({tag, "_flags"}, obytes[2], {6'b0, flg_m[idx]});
`endif
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] got;
  int e0, idx, op, cyc;

  initial begin
    model_reset();
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NACC; i++) rd(i, "rst_rd", got);

    // Basic MAC, accumulate, cancellation, saturation, underflow.
    clr(0); mac(0, 16'h3F00, 16'h4000); rd(0, "basic", got);
    check("basic_const", got, 16'h4100);
    mac(0, 16'h3E00, 16'h3E00); rd(0, "accum", got);
    check("accum_const", got, 16'h4200);
    ld(1, 16'h4100); mac(1, 16'hBF00, 16'h4000); rd(1, "cancel", got);
    check("cancel_const", got, 16'h0000);
    ld(2, 16'h7DFF); mac(2, 16'h7DFF, 16'h4000); rd(2, "sat", got);
    check("sat_const", got, 16'h7DFF);
    clr(3); mac(3, 16'h0200, 16'h0200); rd(3, "uflow", got);
    check("uflow_const", got, 16'h0000);
    ld(3, 16'hFE00); rd(3, "ld_e63", got);
    check("ld_e63_const", got, 16'hFDFF);
    ld(3, 16'h01AB); rd(3, "ld_e0", got);
    check("ld_e0_const", got, 16'h0000);

    // Bad index: whole frame consumed, one err pulse, nothing changes.
    e0 = err_pulses;
    mac(5, 16'h3F00, 16'h4000);
    repeat (4) @(posedge clk);
    #1;
    check("bad_mac_err", err_pulses - e0, 1);
    e0 = err_pulses;
    obytes.delete();
    push(8'h86);
    repeat (6) @(posedge clk);
    #1;
    check("bad_rd_err", err_pulses - e0, 1);
    check("bad_rd_nobytes", obytes.size(), 0);
    for (int i = 0; i < NACC; i++) rd(i, "bad_iso", got);
    ld(3, 16'h4567); rd(0, "iso0", got); rd(3, "iso3", got);

    // Random command stream with handshake gaps and enable drops.
    mode = 1;
    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, NACC - 1);
      op  = $urandom_range(0, 9);
      if (op < 5) mac(idx, rnd_val(), rnd_val());
      else if (op < 6) clr(idx);
      else if (op < 8) ld(idx, rnd_val());
      else rd(idx, "rand_rd", got);
    end
    for (int i = 0; i < NACC; i++) rd(i, "rand_final", got);
    mode = 0;
    @(posedge clk);
    #1;
    check("err_total", err_pulses, 2);
    check("out_hold_stable", hold_viol, 0);

    // Async reset during the third MAC payload byte.
    ld(0, 16'h4321);
    push(8'h00); push(8'h3F); push(8'h00);
    in_valid = 1'b1;
    in_data  = 8'h40;
    #2 rst_n = 1'b0;
    #1;
    check("rst_frame_out_valid", out_valid, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < NACC; i++) rd(i, "rst_frame_rd", got);

    // Async reset while a READ result is stalled.
    ld(2, 16'h4321);
    mode = 2;
    @(posedge clk);
    #1;
    push(8'h82);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("send_hi_byte", {out_valid, out_data}, {1'b1, 8'h43});
    #2 rst_n = 1'b0;
    #1;
    check("rst_send_out_valid", out_valid, 0);
    check("rst_send_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode  = 0;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < NACC; i++) rd(i, "rst_send_rd", got);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
